// File: rtl/snn_spike_encoder.sv
// -----------------------------------------------------------------------------
// snn_spike_encoder
//   Rate encoder for a spiking neural network front end. The encoder latches
//   one unsigned intensity per channel. It then runs a window of 2^VW ticks.
//   On every tick each channel adds its intensity into a VW-bit phase
//   accumulator, and the carry out of that add is the spike. Over one window,
//   channel i therefore fires exactly value_i times, spread evenly. One tick
//   lasts TICK_DIV clock cycles.
//
// Ports
//   CLK        sole clock, rising edge
//   nRST       synchronous active-low reset
//   in_valid   intensity vector offered
//   in_ready   encoder idle and able to take a vector (low while stop is high)
//   in_values  NCH x VW unsigned intensities, channel i at [i*VW +: VW]
//   stop       synchronous abort of the current window
//   spike_out  one-cycle spike pulses, bit i = channel i
//   busy       high while a window is running or completing
//   win_done   one-cycle pulse at the end of a completed window
// -----------------------------------------------------------------------------
module snn_spike_encoder #(
   parameter int NCH      = 4,
   parameter int VW       = 4,
   parameter int TICK_DIV = 10
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [NCH*VW-1:0]  in_values,
   input  logic               stop,
   output logic [NCH-1:0]     spike_out,
   output logic               busy,
   output logic               win_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] PRESC_LAST = 8'(TICK_DIV - 1);

   state_t              state, state_nx;
   logic [7:0]          presc, presc_nx;
   logic [VW-1:0]       tick_cnt, tick_cnt_nx;
   logic [NCH*VW-1:0]   vals, vals_nx;
   logic [NCH*VW-1:0]   acc, acc_nx;
   logic [NCH-1:0]      spike_nx;
   logic                win_done_nx;
   logic [VW:0]         sum [NCH];
   logic                tick;
   logic                accept;

   assign in_ready = (state == IDLE) && !stop;
   assign busy     = (state != IDLE);
   assign accept   = in_valid && in_ready;
   assign tick     = (presc == PRESC_LAST);

   // Per-channel accumulator + intensity; the top bit is the spike carry.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         sum[i] = {1'b0, acc[i*VW +: VW]} + {1'b0, vals[i*VW +: VW]};
      end
   end

   // Next-state and next-output logic for the window sequencer.
   always_comb begin
      state_nx    = state;
      presc_nx    = presc;
      tick_cnt_nx = tick_cnt;
      vals_nx     = vals;
      acc_nx      = acc;
      spike_nx    = '0;
      win_done_nx = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               vals_nx     = in_values;
               acc_nx      = '0;
               presc_nx    = 8'd0;
               tick_cnt_nx = '0;
               state_nx    = RUN;
            end else begin
               state_nx = IDLE;
            end
         end
         RUN: begin
            if (stop) begin
               state_nx = IDLE;
            end else if (tick) begin
               presc_nx = 8'd0;
               for (int i = 0; i < NCH; i++) begin
                  acc_nx[i*VW +: VW] = sum[i][VW-1:0];
                  spike_nx[i]        = sum[i][VW];
               end
               tick_cnt_nx = tick_cnt + VW'(1);
               // The counter wraps on tick number 2^VW, which ends the window.
               if (tick_cnt == {VW{1'b1}}) begin
                  state_nx    = DONE;
                  win_done_nx = 1'b1;
               end else begin
                  state_nx = RUN;
               end
            end else begin
               presc_nx = presc + 8'd1;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state     <= IDLE;
         presc     <= 8'd0;
         tick_cnt  <= '0;
         vals      <= '0;
         acc       <= '0;
         spike_out <= '0;
         win_done  <= 1'b0;
      end else begin
         state     <= state_nx;
         presc     <= presc_nx;
         tick_cnt  <= tick_cnt_nx;
         vals      <= vals_nx;
         acc       <= acc_nx;
         spike_out <= spike_nx;
         win_done  <= win_done_nx;
      end
   end

endmodule

// File: tb/tb_snn_spike_encoder.sv
// -----------------------------------------------------------------------------
// tb_snn_spike_encoder
//   Two encoder instances: dut 0 with TICK_DIV=1 and dut 1 with TICK_DIV=10.
//   The reference model tracks each window by its start cycle. It derives
//   every spike from elapsed time: tick k fires channel i when
//   floor(k*v/16) steps up.
// -----------------------------------------------------------------------------
module tb_snn_spike_encoder;

   logic        clk = 1'b0;
   logic        nrst;
   logic        iv   [2];
   logic [15:0] vin  [2];
   logic        stp  [2];
   logic        rdy  [2];
   logic [3:0]  spk  [2];
   logic        bsy  [2];
   logic        wd   [2];

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   bit known    = 1'b0;

   int mode    [2];      // 0 idle, 1 run, 2 done
   int start   [2];
   int mval    [2][4];
   int obs_cnt [2][4];
   int td      [2];
   int exp_spk [2];
   int exp_wd  [2];
   bit fin     [2];

   always #5 clk = ~clk;

   snn_spike_encoder #(.NCH(4), .VW(4), .TICK_DIV(1)) dut0 (
      .CLK(clk), .nRST(nrst), .in_valid(iv[0]), .in_ready(rdy[0]),
      .in_values(vin[0]), .stop(stp[0]), .spike_out(spk[0]),
      .busy(bsy[0]), .win_done(wd[0])
   );

   snn_spike_encoder #(.NCH(4), .VW(4), .TICK_DIV(10)) dut1 (
      .CLK(clk), .nRST(nrst), .in_valid(iv[1]), .in_ready(rdy[1]),
      .in_values(vin[1]), .stop(stp[1]), .spike_out(spk[1]),
      .busy(bsy[1]), .win_done(wd[1])
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   // Reference model: what one rising edge does for dut d.
   task automatic model_edge(input int d);
      int e, k, v;
      exp_spk[d] = 0;
      exp_wd[d]  = 0;
      fin[d]     = 1'b0;
      if (!nrst) begin
         mode[d] = 0;
      end else if (mode[d] == 0) begin
         if (iv[d] && !stp[d]) begin
            mode[d]  = 1;
            start[d] = cyc;
            for (int c = 0; c < 4; c++) begin
               mval[d][c]    = int'((vin[d] >> (4 * c)) & 16'hF);
               obs_cnt[d][c] = 0;
            end
         end
      end else if (stp[d] || mode[d] == 2) begin
         mode[d] = 0;
      end else begin
         e = cyc - start[d];
         if (e % td[d] == 0) begin
            k = e / td[d];
            for (int c = 0; c < 4; c++) begin
               v = mval[d][c];
               if ((k * v) / 16 != ((k - 1) * v) / 16) exp_spk[d] |= (1 << c);
            end
            if (k == 16) begin
               mode[d]   = 2;
               exp_wd[d] = 1;
               fin[d]    = 1'b1;
            end
         end
      end
   endtask

   // One clock cycle: check in_ready before the edge, then the registered outputs after it.
   task automatic tick_clk();
      #1;
      if (known) begin
         for (int d = 0; d < 2; d++)
            check($sformatf("in_ready%0d", d), int'(rdy[d]), (mode[d] == 0 && !stp[d]) ? 1 : 0);
      end
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) model_edge(d);
      if (!nrst) known = 1'b1;
      #1;
      if (known) begin
         for (int d = 0; d < 2; d++) begin
            check($sformatf("spike_out%0d", d), int'(spk[d]), exp_spk[d]);
            check($sformatf("win_done%0d", d), int'(wd[d]), exp_wd[d]);
            check($sformatf("busy%0d", d), int'(bsy[d]), (mode[d] != 0) ? 1 : 0);
            for (int c = 0; c < 4; c++) obs_cnt[d][c] += int'(spk[d][c]);
            if (fin[d]) begin
               for (int c = 0; c < 4; c++)
                  check($sformatf("count%0d_ch%0d", d, c), obs_cnt[d][c], mval[d][c]);
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic offer(input int d, input logic [15:0] v);
      iv[d]  = 1'b1;
      vin[d] = v;
      tick_clk();
      iv[d]  = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) tick_clk();
   endtask

   initial begin
      td[0] = 1;
      td[1] = 10;
      for (int d = 0; d < 2; d++) begin
         mode[d] = 0; start[d] = 0; iv[d] = 1'b1; stp[d] = 1'b0;
         vin[d] = 16'h6CB2;
         for (int c = 0; c < 4; c++) begin
            mval[d][c] = 0; obs_cnt[d][c] = 0;
         end
      end
      nrst = 1'b0;
      @(negedge clk);

      // Reset held two cycles with in_valid high: nothing may be accepted.
      run(2);
      nrst  = 1'b1;
      iv[0] = 1'b0;
      iv[1] = 1'b0;
      run(2);

      // Mixed intensities 2,11,12,6 on the TICK_DIV=1 encoder.
      offer(0, {4'd6, 4'd12, 4'd11, 4'd2});
      run(18);
      // Boundary intensities on channel 0.
      offer(0, {4'd0, 4'd0, 4'd0, 4'd8});
      run(18);
      offer(0, {4'd0, 4'd0, 4'd0, 4'd15});
      run(18);
      offer(0, {4'd0, 4'd0, 4'd0, 4'd0});
      run(18);

      // Single spike on ch1 with TICK_DIV=10: fires only on tick 16.
      offer(1, {4'd0, 4'd0, 4'd1, 4'd0});
      run(165);

      // Abort at tick 5, with in_valid pulsed while running.
      offer(0, {4'd15, 4'd7, 4'd3, 4'd9});
      iv[0]  = 1'b1;
      vin[0] = 16'hFFFF;
      run(4);
      iv[0]  = 1'b0;
      stp[0] = 1'b1;
      tick_clk();
      stp[0] = 1'b0;
      run(3);
      offer(0, {4'd1, 4'd5, 4'd10, 4'd13});
      run(18);

      // Reset at tick 8 of a TICK_DIV=10 window, then a clean window.
      offer(1, {4'd15, 4'd9, 4'd4, 4'd7});
      run(79);
      nrst = 1'b0;
      tick_clk();
      nrst = 1'b1;
      run(2);
      offer(1, {4'd3, 4'd16 - 4'd1, 4'd6, 4'd11});
      run(165);

      // Randomized traffic.
      for (int i = 0; i < 6000; i++) begin
         nrst = ($urandom_range(0, 499) != 0);
         for (int d = 0; d < 2; d++) begin
            iv[d]  = ($urandom_range(0, 3) == 0);
            vin[d] = 16'($urandom);
            stp[d] = ($urandom_range(0, 99) == 0);
         end
         tick_clk();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/snn_spike_encoder.md
SNN_SPIKE_ENCODER -- requirements
Module: snn_spike_encoder

Interface
REQ-001 SHALL have parameter NCH, default 4, number of spike channels.
REQ-002 SHALL have parameter VW, default 4, intensity width per channel; window = 2^VW ticks.
REQ-003 SHALL have parameter TICK_DIV, default 10, clock cycles per tick (legal range 1..255).
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 nRST  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  intensity vector offered.
REQ-007 in_ready  output  1  encoder can accept a vector.
REQ-008 in_values  input  NCH*VW  channel i intensity at bits [i*VW +: VW], unsigned.
REQ-009 stop  input  1  synchronous abort of the current window.
REQ-010 spike_out  output  NCH  one-cycle spike pulses, bit i = channel i; directly drives a LIF neuron spike_in bus.
REQ-011 busy  output  1  high while state is not IDLE.
REQ-012 win_done  output  1  one-cycle pulse at the end of a completed window.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE.
REQ-014 in_ready SHALL equal (state==IDLE) AND NOT stop.
REQ-015 On an edge with in_valid AND in_ready: latch in_values, clear all accumulators, prescaler and tick counter, enter RUN.
REQ-016 in_valid while not in_ready SHALL be ignored; latched values unchanged.
REQ-017 In RUN, prescaler SHALL count 0..TICK_DIV-1 and wrap; a tick occurs on the edge where prescaler==TICK_DIV-1.
REQ-018 On each tick, per channel: {carry,acc} = acc + value, VW-bit acc modulo 2^VW; spike_out[i] registered = carry.
REQ-019 On every non-tick edge, spike_out SHALL be registered to all zeros; each spike is high exactly one cycle.
REQ-020 First tick SHALL occur TICK_DIV edges after the accepting edge.
REQ-021 Over one window, channel i SHALL emit exactly value_i spikes; value 0 gives none; first spike at tick ceil(2^VW/value_i).
REQ-022 Tick counter (VW bits) SHALL count ticks; on tick number 2^VW, state becomes DONE.
REQ-023 DONE SHALL last exactly one cycle with win_done=1, then go to IDLE.
REQ-024 stop high in RUN or DONE SHALL force IDLE, spike_out=0, win_done=0 at the next edge; no win_done for an aborted window.
REQ-025 stop and in_valid together in IDLE: stop wins, vector not accepted.
REQ-026 New vector SHALL not be accepted before the cycle after DONE (in_ready low in DONE).

Reset
REQ-027 nRST=0 at an edge SHALL set state IDLE, spike_out=0, win_done=0, busy=0, accumulators, prescaler, tick counter and latched values to 0; in_ready=1 the cycle after (stop low).
REQ-028 Reset mid-RUN SHALL take precedence over tick, stop and in_valid; no further spikes until a new vector is accepted.

Verification
REQ-029 Reset: hold nRST=0 for 2 cycles with in_valid=1 -> spike_out=0, busy=0, win_done=0, nothing accepted; in_ready=1 after release.
REQ-030 TICK_DIV=1, values ch0..3 = 2,11,12,6 -> spike counts 2,11,12,6 over 16 ticks; win_done high 1 cycle, 16 cycles after accept edge; in_ready returns next cycle.
REQ-031 TICK_DIV=1, ch0=8 -> ch0 spikes on ticks 2,4,...,16; ch0=15 -> first spike tick 2, 15 total; ch0=0 -> no spikes.
REQ-032 TICK_DIV=10, ch1=1 -> single spike at tick 16 (160 cycles after accept); all spikes aligned to multiples of 10 cycles.
REQ-033 stop asserted at tick 5 -> spike_out=0 and in_ready=1 next cycle, no win_done; in_valid during RUN ignored, counts unchanged.
REQ-034 nRST=0 at tick 8 of a window -> outputs cleared next edge; subsequent vector gives exact counts.
